// File: rtl/pingpong_bank_sched_pkg.sv
// Shared encodings for the ping-pong bank scheduler: per-bank state and
// the producer/consumer FSM states.
package pingpong_bank_sched_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        FILLING  = 2'b01,
        FULL     = 2'b10,
        DRAINING = 2'b11
    } bank_state_t;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_FILL = 1'b1
    } prod_state_t;

    typedef enum logic [1:0] {
        C_IDLE     = 2'b00,
        C_WAIT_ACK = 2'b01,
        C_BUSY     = 2'b10
    } cons_state_t;

    // FULL and DRAINING both hold a complete frame; the encoding puts that in bit 1.
    function automatic logic bank_holds_frame(input bank_state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/pingpong_bank_sched_slot.sv
// One feature-map bank's lifecycle register, advanced by one-hot strobes
// from the producer and consumer FSMs of the scheduler.
module pp_bank_slot
    import pingpong_bank_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        set_fill,
    input  logic        set_full,
    input  logic        set_drain,
    input  logic        set_empty,
    output bank_state_t state
);

    // The FSMs never strobe the same bank twice in one cycle; priority is only a tie-break.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else if (set_fill) begin
            state <= FILLING;
        end else if (set_full) begin
            state <= FULL;
        end else if (set_drain) begin
            state <= DRAINING;
        end else if (set_empty) begin
            state <= EMPTY;
        end
    end

endmodule

// File: rtl/pingpong_bank_sched.sv
// Ping-pong bank scheduler between a producer layer and its consumer layer:
// grants banks to the producer, launches the consumer on full banks, recycles drained banks.
module pingpong_bank_sched
    import pingpong_bank_sched_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prod_req,
    input  logic             prod_frame_done,
    output logic             prod_start,
    output logic             wr_bank_sel,
    input  logic             cons_end,
    output logic             cons_start,
    output logic             rd_bank_sel,
    output logic [1:0]       bank_full,
    output logic [CNT_W-1:0] frames_done,
    output logic             err,
    output logic             dbg_prod_state,
    output logic [1:0]       dbg_cons_state
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    prod_state_t     p_state, p_next;
    cons_state_t     c_state, c_next;
    bank_state_t     slot_state [2];
    logic [TO_W-1:0] ack_cnt;
    logic            p_grant, p_done, p_spurious;
    logic            c_launch, c_timeout, c_release;
    logic [1:0]      set_fill, set_full, set_drain, set_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state <= P_IDLE;
            c_state <= C_IDLE;
        end else begin
            p_state <= p_next;
            c_state <= c_next;
        end
    end

    always_comb begin
        p_next = p_state;
        unique case (p_state)
            P_IDLE:  if (p_grant)         p_next = P_FILL;
            P_FILL:  if (prod_frame_done) p_next = P_IDLE;
            default:                      p_next = P_IDLE;
        endcase
        c_next = c_state;
        unique case (c_state)
            C_IDLE:     if (c_launch)              c_next = C_WAIT_ACK;
            C_WAIT_ACK: if (!cons_end || c_timeout) c_next = C_BUSY;
            C_BUSY:     if (cons_end)              c_next = C_IDLE;
            default:                               c_next = C_IDLE;
        endcase
    end

    // Handshake: prod_start/cons_start are single-cycle registered pulses; the
    // producer acknowledges with a prod_frame_done pulse, the consumer by
    // dropping cons_end and later raising it when it has finished the bank.
    always_comb begin
        p_spurious = (p_state == P_IDLE) && prod_frame_done;
        p_grant    = (p_state == P_IDLE) && !prod_frame_done && prod_req &&
                     (slot_state[wr_bank_sel] == EMPTY);
        p_done     = (p_state == P_FILL) && prod_frame_done;
        c_launch   = (c_state == C_IDLE) && cons_end && (slot_state[rd_bank_sel] == FULL);
        c_timeout  = (c_state == C_WAIT_ACK) && cons_end &&
                     (ack_cnt == TO_W'(ACK_TIMEOUT - 1));
        c_release  = (c_state == C_BUSY) && cons_end;
        set_fill   = {p_grant   &  wr_bank_sel, p_grant   & ~wr_bank_sel};
        set_full   = {p_done    &  wr_bank_sel, p_done    & ~wr_bank_sel};
        set_drain  = {c_launch  &  rd_bank_sel, c_launch  & ~rd_bank_sel};
        set_empty  = {c_release &  rd_bank_sel, c_release & ~rd_bank_sel};
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        pp_bank_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .set_fill  (set_fill[i]),
            .set_full  (set_full[i]),
            .set_drain (set_drain[i]),
            .set_empty (set_empty[i]),
            .state     (slot_state[i])
        );
        assign bank_full[i] = bank_holds_frame(slot_state[i]);
    end

    // Counts cycles the consumer has kept cons_end high since its start pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_cnt <= '0;
        end else if (c_launch) begin
            ack_cnt <= '0;
        end else if (c_state == C_WAIT_ACK && cons_end) begin
            ack_cnt <= ack_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_start  <= 1'b0;
            cons_start  <= 1'b0;
            wr_bank_sel <= 1'b0;
            rd_bank_sel <= 1'b0;
            frames_done <= '0;
            err         <= 1'b0;
        end else begin
            prod_start <= p_grant;
            cons_start <= c_launch;
            if (p_done) begin
                wr_bank_sel <= ~wr_bank_sel;
            end
            if (c_release) begin
                rd_bank_sel <= ~rd_bank_sel;
                frames_done <= frames_done + CNT_W'(1);
            end
            if (p_spurious || c_timeout) begin
                err <= 1'b1;
            end
        end
    end

    assign dbg_prod_state = p_state;
    assign dbg_cons_state = c_state;

endmodule

// File: tb/tb_pingpong_bank_sched.sv
// Bench for pingpong_bank_sched: a single-frame vector table, directed
// corner-case sequences, and randomized traffic against a bank-lifecycle model.
module tb_pingpong_bank_sched;

    localparam int ACK_TIMEOUT = 16;
    localparam int CNT_W       = 16;
    localparam int OUT_W       = 7 + CNT_W;
    localparam int M_EMPTY = 0, M_FILLING = 1, M_FULL = 2, M_DRAINING = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             prod_req = 1'b0;
    logic             prod_frame_done = 1'b0;
    logic             cons_end = 1'b0;
    logic             prod_start, wr_bank_sel, cons_start, rd_bank_sel, err;
    logic [1:0]       bank_full;
    logic [CNT_W-1:0] frames_done;
    logic             dbg_prod_state;
    logic [1:0]       dbg_cons_state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic             req, done, cend;
        logic             e_ps, e_cs, e_wr, e_rd;
        logic [1:0]       e_bf;
        logic [CNT_W-1:0] e_fd;
        logic             e_err;
    } vec_t;
    vec_t tbl [23];

    logic [OUT_W-1:0] exp_q [$];

    // model of the banks and the two agents, kept as plain lifecycle bookkeeping
    int   m_bank [2];
    logic m_filling, m_ps, m_cs, m_wsel, m_rsel, m_err;
    int   m_phase, m_wait, m_frames;

    // clock / reset
    always #5 clk = ~clk;

    pingpong_bank_sched #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .prod_req        (prod_req),
        .prod_frame_done (prod_frame_done),
        .prod_start      (prod_start),
        .wr_bank_sel     (wr_bank_sel),
        .cons_end        (cons_end),
        .cons_start      (cons_start),
        .rd_bank_sel     (rd_bank_sel),
        .bank_full       (bank_full),
        .frames_done     (frames_done),
        .err             (err),
        .dbg_prod_state  (dbg_prod_state),
        .dbg_cons_state  (dbg_cons_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] dut_out();
        return {prod_start, cons_start, wr_bank_sel, rd_bank_sel, bank_full, frames_done, err};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        prod_req = 1'b0;
        prod_frame_done = 1'b0;
        cons_end = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill_single_frame();
        for (int k = 0; k < 23; k++) begin
            tbl[k].req   = (k == 0);
            tbl[k].done  = (k == 10);
            tbl[k].cend  = !(k >= 13 && k <= 19);
            tbl[k].e_ps  = (k == 1);
            tbl[k].e_cs  = (k == 12);
            tbl[k].e_wr  = (k >= 11);
            tbl[k].e_rd  = (k >= 21);
            tbl[k].e_bf  = (k >= 11 && k <= 20) ? 2'b01 : 2'b00;
            tbl[k].e_fd  = (k >= 21) ? CNT_W'(1) : CNT_W'(0);
            tbl[k].e_err = 1'b0;
        end
    endtask

    task automatic run_table(input string tag, input int rows);
        logic [OUT_W-1:0] exp;
        for (int k = 0; k < rows; k++) begin
            prod_req = tbl[k].req;
            prod_frame_done = tbl[k].done;
            cons_end = tbl[k].cend;
            exp = {tbl[k].e_ps, tbl[k].e_cs, tbl[k].e_wr, tbl[k].e_rd,
                   tbl[k].e_bf, tbl[k].e_fd, tbl[k].e_err};
            chk($sformatf("%s row %0d", tag, k), 32'(dut_out()), 32'(exp));
            cyc();
        end
    endtask

    task automatic model_reset();
        m_bank[0] = M_EMPTY;
        m_bank[1] = M_EMPTY;
        m_filling = 1'b0; m_ps = 1'b0; m_cs = 1'b0;
        m_wsel = 1'b0; m_rsel = 1'b0; m_err = 1'b0;
        m_phase = 0; m_wait = 0; m_frames = 0;
    endtask

    task automatic model_step();
        int old_bank [2];
        old_bank = m_bank;
        m_ps = 1'b0;
        m_cs = 1'b0;
        if (!m_filling) begin
            if (prod_frame_done) begin
                m_err = 1'b1;
            end else if (prod_req && old_bank[m_wsel] == M_EMPTY) begin
                m_ps = 1'b1;
                m_bank[m_wsel] = M_FILLING;
                m_filling = 1'b1;
            end
        end else if (prod_frame_done) begin
            m_bank[m_wsel] = M_FULL;
            m_wsel = ~m_wsel;
            m_filling = 1'b0;
        end
        case (m_phase)
            0: if (cons_end && old_bank[m_rsel] == M_FULL) begin
                m_cs = 1'b1;
                m_bank[m_rsel] = M_DRAINING;
                m_phase = 1;
                m_wait = 0;
            end
            1: if (!cons_end) begin
                m_phase = 2;
            end else begin
                m_wait++;
                if (m_wait == ACK_TIMEOUT) begin
                    m_err = 1'b1;
                    m_phase = 2;
                end
            end
            default: if (cons_end) begin
                m_bank[m_rsel] = M_EMPTY;
                m_rsel = ~m_rsel;
                m_frames++;
                m_phase = 0;
            end
        endcase
    endtask

    function automatic logic [OUT_W-1:0] model_out();
        logic [1:0] bf;
        bf[0] = (m_bank[0] >= M_FULL);
        bf[1] = (m_bank[1] >= M_FULL);
        return {m_ps, m_cs, m_wsel, m_rsel, bf, CNT_W'(m_frames), m_err};
    endfunction

    initial begin
        int n_ps, n_cs;
        logic [OUT_W-1:0] exp;

        fill_single_frame();

        // single frame, vector table
        do_reset();
        run_table("single_frame", 23);

        // backpressure: two frames, consumer never idle
        do_reset();
        n_ps = 0;
        n_cs = 0;
        for (int k = 0; k < 70; k++) begin
            prod_req = 1'b1;
            cons_end = 1'b0;
            prod_frame_done = (k == 3 || k == 7);
            if (prod_start) n_ps++;
            if (cons_start) n_cs++;
            if (k == 8) chk("backpressure bank_full k8", 32'(bank_full), 32'h3);
            cyc();
        end
        chk("backpressure prod_start count", n_ps, 2);
        chk("backpressure cons_start count", n_cs, 0);
        chk("backpressure bank_full end", 32'(bank_full), 32'h3);
        chk("backpressure err", 32'(err), 32'h0);

        // overlap: producer completes bank 1 while consumer releases bank 0
        do_reset();
        for (int k = 0; k < 12; k++) begin
            prod_req = 1'b1;
            cons_end = !(k >= 5 && k <= 7);
            prod_frame_done = (k == 2 || k == 8);
            if (k == 4) begin
                chk("overlap prod_start k4", 32'(prod_start), 32'h1);
                chk("overlap cons_start k4", 32'(cons_start), 32'h1);
            end
            if (k == 8) begin
                chk("overlap bank_full k8", 32'(bank_full), 32'h1);
                chk("overlap wr_sel k8", 32'(wr_bank_sel), 32'h1);
                chk("overlap rd_sel k8", 32'(rd_bank_sel), 32'h0);
            end
            if (k == 9) begin
                chk("overlap bank_full k9", 32'(bank_full), 32'h2);
                chk("overlap wr_sel k9", 32'(wr_bank_sel), 32'h0);
                chk("overlap rd_sel k9", 32'(rd_bank_sel), 32'h1);
                chk("overlap frames k9", 32'(frames_done), 32'h1);
                chk("overlap no same-cycle regrant k9", 32'(prod_start), 32'h0);
            end
            if (k == 10) begin
                chk("overlap regrant k10", 32'(prod_start), 32'h1);
                chk("overlap cons_start k10", 32'(cons_start), 32'h1);
                chk("overlap err k10", 32'(err), 32'h0);
            end
            cyc();
        end

        // timeout: consumer never drops cons_end after its start pulse
        do_reset();
        for (int k = 0; k < 36; k++) begin
            prod_req = (k == 0);
            prod_frame_done = (k == 2);
            cons_end = 1'b1;
            if (k == 4)  chk("timeout cons_start k4", 32'(cons_start), 32'h1);
            if (k == 19) chk("timeout err before k19", 32'(err), 32'h0);
            if (k == 20) chk("timeout err set k20", 32'(err), 32'h1);
            if (k == 35) chk("timeout err sticky k35", 32'(err), 32'h1);
            cyc();
        end

        // spurious frame_done while producer idle
        do_reset();
        prod_frame_done = 1'b1;
        cyc();
        prod_frame_done = 1'b0;
        chk("spurious err", 32'(err), 32'h1);
        chk("spurious bank_full", 32'(bank_full), 32'h0);
        chk("spurious wr_sel", 32'(wr_bank_sel), 32'h0);
        prod_req = 1'b1;
        cyc();
        prod_req = 1'b0;
        chk("spurious then grant", 32'(prod_start), 32'h1);

        // reset mid-drain, asynchronous, then a fresh frame
        do_reset();
        run_table("pre_reset", 16);
        chk("mid_drain bank_full before reset", 32'(bank_full), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset outputs", 32'(dut_out()), 32'h0);
        chk("async reset prod dbg", 32'(dbg_prod_state), 32'h0);
        chk("async reset cons dbg", 32'(dbg_cons_state), 32'h0);
        prod_req = 1'b0;
        prod_frame_done = 1'b0;
        cons_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("held reset outputs", 32'(dut_out()), 32'h0);
        reset = 1'b1;
        run_table("post_reset", 23);

        // randomized traffic against the model through the expected queue
        do_reset();
        model_reset();
        exp_q.push_back(model_out());
        for (int n = 0; n < 3000; n++) begin
            exp = exp_q.pop_front();
            chk($sformatf("random cyc %0d", n), 32'(dut_out()), 32'(exp));
            prod_req = ($urandom_range(0, 3) != 0);
            if (m_filling) begin
                prod_frame_done = ($urandom_range(0, 5) == 0);
            end else begin
                prod_frame_done = (n > 2500) && ($urandom_range(0, 99) == 0);
            end
            if ($urandom_range(0, 3) == 0) cons_end = ~cons_end;
            @(posedge clk);
            model_step();
            exp_q.push_back(model_out());
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
